// File: rtl/axi_slave_resp_push_ctrl_if.sv
// ----------------------------------------------------------------------------
// axi_slave_resp_push_ctrl_if
//
// Purpose:
//   Bundles the completion-descriptor input, the read-data beat input and the
//   R/B response-buffer push outputs of axi_slave_resp_push_ctrl.
//
// Handshake rule (all channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. Valid never depends on ready. The buffer side has no ready: a push
//   strobe is a one-cycle write that is only issued while the buffer's full
//   flag is low.
//
// Signals:
//   cpl_*   completion descriptor from the completion parser
//   dat_*   read data beats
//   rbuf_*  R-channel response-buffer write port
//   bbuf_*  B-channel response-buffer write port
//   busy    controller is sequencing a descriptor
//
// Modports:
//   slave   the controller itself
//   master  the surrounding logic (parser, data source, buffers)
// ----------------------------------------------------------------------------
interface axi_slave_resp_push_ctrl_if #(
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 3
);
    logic                   cpl_valid;
    logic                   cpl_ready;
    logic                   cpl_is_write;
    logic [ID_WIDTH-1:0]    cpl_id;
    logic [COUNT_WIDTH-1:0] cpl_len;
    logic [1:0]             cpl_resp;

    logic                   dat_valid;
    logic                   dat_ready;
    logic [DATA_WIDTH-1:0]  dat_data;

    logic                   rbuf_full;
    logic                   rbuf_push;
    logic [DATA_WIDTH-1:0]  rbuf_data;
    logic [ID_WIDTH-1:0]    rbuf_id;
    logic [1:0]             rbuf_resp;
    logic                   rbuf_last;

    logic                   bbuf_full;
    logic                   bbuf_push;
    logic [ID_WIDTH-1:0]    bbuf_id;
    logic [1:0]             bbuf_resp;

    logic                   busy;

    modport slave (
        input  cpl_valid, cpl_is_write, cpl_id, cpl_len, cpl_resp,
        input  dat_valid, dat_data,
        input  rbuf_full, bbuf_full,
        output cpl_ready, dat_ready,
        output rbuf_push, rbuf_data, rbuf_id, rbuf_resp, rbuf_last,
        output bbuf_push, bbuf_id, bbuf_resp,
        output busy
    );

    modport master (
        output cpl_valid, cpl_is_write, cpl_id, cpl_len, cpl_resp,
        output dat_valid, dat_data,
        output rbuf_full, bbuf_full,
        input  cpl_ready, dat_ready,
        input  rbuf_push, rbuf_data, rbuf_id, rbuf_resp, rbuf_last,
        input  bbuf_push, bbuf_id, bbuf_resp,
        input  busy
    );
endinterface

// File: rtl/axi_slave_resp_push_ctrl.sv
// ----------------------------------------------------------------------------
// axi_slave_resp_push_ctrl
//
// Purpose:
//   Sequences the AXI slave response path. One completion descriptor is
//   accepted at a time. A read descriptor streams cpl_len+1 data beats into
//   the R buffer (LAST on the final beat); a write descriptor pushes a single
//   B response. The descriptor's ID and RESP are held for the whole response.
//
// Ports:
//   clk          rising-edge clock
//   arst         asynchronous reset, active-high
//   bus          axi_slave_resp_push_ctrl_if.slave (descriptor, data beats,
//                R/B buffer pushes, busy)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = R_PUSH, 2 = B_PUSH)
// ----------------------------------------------------------------------------
module axi_slave_resp_push_ctrl #(
    parameter int MAX_BEATS   = 8,
    parameter int COUNT_WIDTH = $clog2(MAX_BEATS),
    parameter int ID_WIDTH    = 4,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                        clk,
    input  logic                        arst,
    axi_slave_resp_push_ctrl_if.slave   bus,
    output logic [1:0]                  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_R_PUSH = 2'd1,
        S_B_PUSH = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [COUNT_WIDTH-1:0] r_count;
    logic [ID_WIDTH-1:0]    r_id;
    logic [1:0]             r_resp;

    logic                   w_cpl_hs;
    logic                   w_rpush;
    logic                   w_last;

    // A descriptor can only be taken in IDLE, so the handshake is valid & IDLE.
    assign w_cpl_hs = (r_state == S_IDLE) & bus.cpl_valid;
    // An R push consumes one data beat in the same cycle.
    assign w_rpush  = (r_state == S_R_PUSH) & bus.dat_valid & ~bus.rbuf_full;
    // The counter holds the beats remaining after the current one.
    assign w_last   = (r_count == '0);

    assign o_dbg_state = r_state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cpl_hs) begin
                    w_next_state = bus.cpl_is_write ? S_B_PUSH : S_R_PUSH;
                end
            end
            S_R_PUSH: begin
                if (w_rpush && w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            S_B_PUSH: begin
                if (!bus.bbuf_full) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Payload outputs are forced to zero outside the state
    // that owns them so that idle and reset present a clean all-zero bus.
    // ------------------------------------------------------------------
    always_comb begin
        bus.cpl_ready = 1'b0;
        bus.dat_ready = 1'b0;
        bus.rbuf_push = 1'b0;
        bus.rbuf_data = '0;
        bus.rbuf_id   = '0;
        bus.rbuf_resp = 2'b00;
        bus.rbuf_last = 1'b0;
        bus.bbuf_push = 1'b0;
        bus.bbuf_id   = '0;
        bus.bbuf_resp = 2'b00;
        bus.busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                bus.cpl_ready = 1'b1;
            end
            S_R_PUSH: begin
                bus.dat_ready = ~bus.rbuf_full;
                bus.rbuf_push = w_rpush;
                bus.rbuf_data = bus.dat_data;
                bus.rbuf_id   = r_id;
                bus.rbuf_resp = r_resp;
                bus.rbuf_last = w_last;
            end
            S_B_PUSH: begin
                bus.bbuf_push = ~bus.bbuf_full;
                bus.bbuf_id   = r_id;
                bus.bbuf_resp = r_resp;
            end
            default: begin
                bus.cpl_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Descriptor capture and beat down-counter. The counter saturates at
    // zero: the final push leaves the FSM instead of wrapping the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_count <= '0;
            r_id    <= '0;
            r_resp  <= 2'b00;
        end else begin
            if (w_cpl_hs) begin
                r_id   <= bus.cpl_id;
                r_resp <= bus.cpl_resp;
                if (!bus.cpl_is_write) begin
                    r_count <= bus.cpl_len;
                end
            end else if (w_rpush && !w_last) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_resp_push_ctrl.sv
// ----------------------------------------------------------------------------
// tb_axi_slave_resp_push_ctrl
//
// Purpose:
//   Self-checking bench for axi_slave_resp_push_ctrl. The reference model
//   keeps the outstanding work as queues: every accepted read adds its beats
//   (data, id, resp, last) to an R queue, every accepted write adds one entry
//   to a B queue. The controller is busy exactly while work is outstanding,
//   and each cycle the expected handshake/push strobes follow from that and
//   from the current stall inputs.
// ----------------------------------------------------------------------------
module tb_axi_slave_resp_push_ctrl;

    localparam int ID_W   = 4;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 3;

    logic       clk = 1'b0;
    logic       arst;
    logic [1:0] dbg_state;

    axi_slave_resp_push_ctrl_if #(
        .ID_WIDTH   (ID_W),
        .DATA_WIDTH (DATA_W),
        .COUNT_WIDTH(CNT_W)
    ) bus ();

    axi_slave_resp_push_ctrl #(
        .MAX_BEATS  (8),
        .COUNT_WIDTH(CNT_W),
        .ID_WIDTH   (ID_W),
        .DATA_WIDTH (DATA_W)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .bus        (bus.slave),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: R entries are {last, resp, id, data}; B entries {resp, id}.
    logic [DATA_W+ID_W+2:0] r_q[$];
    logic [ID_W+1:0]        b_q[$];
    logic [DATA_W-1:0]      src_q[$];

    int tests = 0;
    int fails = 0;
    int n_rpush = 0;
    int n_bpush = 0;
    bit rnd = 0;
    bit accepted = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the data beat, check outputs on the falling
    // edge, update the model with what the rising edge will transfer.
    task automatic tick();
        bit exp_busy, exp_dr, exp_rp, exp_bp;
        if (rnd) begin
            bus.dat_valid = 1'($urandom_range(0, 1));
            bus.rbuf_full = ($urandom_range(0, 3) == 0);
            bus.bbuf_full = ($urandom_range(0, 2) == 0);
        end
        bus.dat_data = (src_q.size() != 0) ? src_q[0] : {$urandom(), $urandom()};
        accepted = 0;
        @(negedge clk);
        exp_busy = (r_q.size() != 0) || (b_q.size() != 0);
        check("cpl_ready", bus.cpl_ready, !exp_busy);
        check("busy", bus.busy, exp_busy);
        exp_dr = (r_q.size() != 0) && !bus.rbuf_full;
        check("dat_ready", bus.dat_ready, exp_dr);
        exp_rp = exp_dr && bus.dat_valid;
        check("rbuf_push", bus.rbuf_push, exp_rp);
        if (exp_rp) begin
            check("r_beat", {bus.rbuf_last, bus.rbuf_resp, bus.rbuf_id, bus.rbuf_data}, r_q[0]);
            void'(r_q.pop_front());
            void'(src_q.pop_front());
            n_rpush++;
        end
        exp_bp = (b_q.size() != 0) && !bus.bbuf_full;
        check("bbuf_push", bus.bbuf_push, exp_bp);
        if (exp_bp) begin
            check("b_resp", {bus.bbuf_resp, bus.bbuf_id}, b_q[0]);
            void'(b_q.pop_front());
            n_bpush++;
        end
        if (bus.cpl_valid && !exp_busy) begin
            accepted = 1;
            if (bus.cpl_is_write) begin
                b_q.push_back({bus.cpl_resp, bus.cpl_id});
            end else begin
                for (int i = 0; i <= int'(bus.cpl_len); i++) begin
                    logic [DATA_W-1:0] d;
                    d = {$urandom(), $urandom()};
                    src_q.push_back(d);
                    r_q.push_back({(i == int'(bus.cpl_len)), bus.cpl_resp, bus.cpl_id, d});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present a descriptor until it is accepted; waited counts the cycles
    // including the handshake cycle.
    task automatic send(input logic w, input logic [ID_W-1:0] id, input logic [CNT_W-1:0] len,
                        input logic [1:0] resp, output int waited);
        bus.cpl_is_write = w;
        bus.cpl_id       = id;
        bus.cpl_len      = len;
        bus.cpl_resp     = resp;
        bus.cpl_valid    = 1'b1;
        waited   = 0;
        accepted = 0;
        while (!accepted && waited < 200) begin
            tick();
            waited++;
        end
        check("send_accepted", accepted, 1'b1);
        bus.cpl_valid    = 1'b0;
        bus.cpl_is_write = 1'($urandom_range(0, 1));
        bus.cpl_len      = CNT_W'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check("drain_empty", r_q.size() + b_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpl_ready"}, bus.cpl_ready, 1'b1);
        check({tag, "_dat_ready"}, bus.dat_ready, 1'b0);
        check({tag, "_rbuf_push"}, bus.rbuf_push, 1'b0);
        check({tag, "_rbuf_last"}, bus.rbuf_last, 1'b0);
        check({tag, "_rbuf_data"}, bus.rbuf_data, 0);
        check({tag, "_rbuf_id"},   bus.rbuf_id, 0);
        check({tag, "_rbuf_resp"}, bus.rbuf_resp, 0);
        check({tag, "_bbuf_push"}, bus.bbuf_push, 1'b0);
        check({tag, "_bbuf_id"},   bus.bbuf_id, 0);
        check({tag, "_bbuf_resp"}, bus.bbuf_resp, 0);
        check({tag, "_busy"},      bus.busy, 1'b0);
        check({tag, "_state"},     dbg_state, 2'd0);
    endtask

    initial begin
        int w;
        int n0;
        arst             = 1'b1;
        bus.cpl_valid    = 1'b0;
        bus.cpl_is_write = 1'b0;
        bus.cpl_id       = '0;
        bus.cpl_len      = '0;
        bus.cpl_resp     = 2'b00;
        bus.dat_valid    = 1'b0;
        bus.dat_data     = '0;
        bus.rbuf_full    = 1'b0;
        bus.bbuf_full    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Read, 4 beats, no stalls: pushes on the 4 cycles after the handshake
        bus.dat_valid = 1'b1;
        send(1'b0, 4'd5, 3'd3, 2'd0, w);
        n0 = n_rpush;
        repeat (4) tick();
        check("t1_pushes", n_rpush - n0, 4);
        tick();
        check("t1_done", r_q.size(), 0);

        // Write with B buffer full for 3 cycles
        send(1'b1, 4'd2, 3'd6, 2'd2, w);
        bus.bbuf_full = 1'b1;
        n0 = n_bpush;
        repeat (3) tick();
        check("t2_stall", n_bpush - n0, 0);
        bus.bbuf_full = 1'b0;
        tick();
        check("t2_push", n_bpush - n0, 1);
        tick();

        // Max-length read with R buffer full on beats 1, 4 and 8
        send(1'b0, 4'd12, 3'd7, 2'd1, w);
        n0 = n_rpush;
        for (int b = 0; b < 8; b++) begin
            if (b == 0 || b == 3 || b == 7) begin
                bus.rbuf_full = 1'b1;
                tick();
            end
            bus.rbuf_full = 1'b0;
            tick();
        end
        check("t3_pushes", n_rpush - n0, 8);
        tick();

        // Single-beat read
        send(1'b0, 4'd9, 3'd0, 2'd3, w);
        n0 = n_rpush;
        tick();
        check("t4_pushes", n_rpush - n0, 1);
        tick();

        // Read then a write presented right away: 3 pushes + 1 IDLE cycle
        send(1'b0, 4'd6, 3'd2, 2'd0, w);
        send(1'b1, 4'd11, 3'd0, 2'd1, w);
        check("t5_b2b_wait", w, 4);
        n0 = n_bpush;
        tick();
        check("t5_bpush", n_bpush - n0, 1);
        tick();

        // Reset after the 2nd of 4 beats
        send(1'b0, 4'd3, 3'd3, 2'd0, w);
        tick();
        tick();
        arst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        r_q.delete();
        b_q.delete();
        src_q.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst_hold");
        arst = 1'b0;
        send(1'b0, 4'd4, 3'd1, 2'd2, w);
        n0 = n_rpush;
        tick();
        tick();
        check("t6_pushes", n_rpush - n0, 2);
        tick();

        // Random traffic with random stalls
        rnd = 1;
        repeat (40) begin
            send(1'($urandom_range(0, 1)), ID_W'($urandom_range(0, 15)),
                 CNT_W'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), w);
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        rnd = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
